// File: rtl/rf_pkg.sv
// Shared defaults and constants for the register-file writeback arbiter.
package rf_pkg;
  localparam int NREQ_DEF       = 3;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_W_DEF      = 2;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_CSR = 2;

  localparam logic [ADDR_WIDTH_DEF-1:0] X0_ADDR = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid index at or after ptr_i, wrapping.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         valid_i,
  input  logic                    en_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o
);
  localparam int PTR_W = $clog2(NREQ);

  logic found;
  int   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (en_i && !found && valid_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PTR_W'(idx);
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the register-file write port with a registered output
// stage and a per-register pending-write scoreboard for decode.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       wb_hold,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  input  logic                       sb_set_valid,
  input  logic [ADDR_WIDTH-1:0]      sb_set_addr,
  output logic                       sb_set_ready,
  input  logic [ADDR_WIDTH-1:0]      sb_raddr,
  output logic                       sb_busy
);
  localparam int PTR_W = $clog2(NREQ);
  localparam int NREG  = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0]      CNT_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] X0      = ADDR_WIDTH'(X0_ADDR);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [NREQ-1:0]       gnt;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sb_inc;

  // Reset also gates the grant so nothing is acknowledged while held in reset.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid_i   (req_valid),
    .en_i      (rst_n & ~wb_hold),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign gnt_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign gnt_data  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rr_ptr_d   = (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      rf_wen_d   = (gnt_addr != X0);
      rf_waddr_d = gnt_addr;
      rf_wdata_d = gnt_data;
    end
  end

  assign sb_set_ready = (cnt_q[sb_set_addr] != CNT_MAX) || (sb_set_addr == X0);
  assign sb_inc       = sb_set_valid && sb_set_ready && (sb_set_addr != X0);
  assign sb_busy      = (cnt_q[sb_raddr] != '0);

  // Retiring write decrements on the same edge the register file captures it.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        if (sb_inc && (sb_set_addr == ADDR_WIDTH'(r)) &&
            !(rf_wen_q && (rf_waddr_q == ADDR_WIDTH'(r))))
          cnt_d[r] = cnt_q[r] + 1'b1;
        else if (rf_wen_q && (rf_waddr_q == ADDR_WIDTH'(r)) &&
                 !(sb_inc && (sb_set_addr == ADDR_WIDTH'(r))) &&
                 (cnt_q[r] != '0))
          cnt_d[r] = cnt_q[r] - 1'b1;
      end else begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, scoreboard sequences, and
// randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int N = 3, AW = 5, DW = 32, NREG = 32, CMAX = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            wb_hold = 1'b0;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            sb_set_valid = 1'b0;
  logic [AW-1:0]   sb_set_addr = '0;
  logic            sb_set_ready;
  logic [AW-1:0]   sb_raddr = '0;
  logic            sb_busy;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_hold(wb_hold),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr),
    .sb_set_ready(sb_set_ready), .sb_raddr(sb_raddr), .sb_busy(sb_busy)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: pending write counts per register, pointer, output stage.
  int         m_ptr, n_ptr, m_waddr, n_waddr;
  bit         m_wen, n_wen, set_acc;
  logic [31:0] m_wdata, n_wdata;
  logic [N-1:0] m_gnt;
  int         m_cnt[NREG], n_cnt[NREG], avail[NREG];

  task automatic model_reset();
    m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = '0;
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
  endtask

  task automatic settle();
    int gi, idx;
    bit ok;
    @(negedge clk);
    gi = -1;
    m_gnt = '0;
    if (!wb_hold)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gi < 0 && req_valid[idx]) gi = idx;
      end
    if (gi >= 0) m_gnt[gi] = 1'b1;
    ok = (m_cnt[sb_set_addr] != CMAX) || (sb_set_addr == 0);
    chk("req_ready", 32'(req_ready), 32'(m_gnt));
    chk("rf_wen", 32'(rf_wen), 32'(m_wen));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("sb_set_ready", 32'(sb_set_ready), 32'(ok));
    chk("sb_busy", 32'(sb_busy), 32'(m_cnt[sb_raddr] != 0));
    if (rf_wen === 1'b1) chk("sb_no_underflow", 32'(m_cnt[rf_waddr] != 0), 32'd1);
    n_cnt = m_cnt;
    set_acc = sb_set_valid && ok && (sb_set_addr != 0);
    if (set_acc) n_cnt[sb_set_addr]++;
    if (m_wen && n_cnt[m_waddr] > 0) n_cnt[m_waddr]--;
    if (gi >= 0) begin
      n_ptr   = (gi + 1) % N;
      n_waddr = int'(req_addr[gi*AW +: AW]);
      n_wen   = (n_waddr != 0);
      n_wdata = req_data[gi*DW +: DW];
    end else begin
      n_ptr = m_ptr; n_wen = 0; n_waddr = m_waddr; n_wdata = m_wdata;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_ptr = n_ptr; m_wen = n_wen; m_waddr = n_waddr; m_wdata = n_wdata;
    m_cnt = n_cnt;
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input int a0, input int a1, input int a2, input bit h);
    req_valid = v;
    req_addr  = {AW'(a2), AW'(a1), AW'(a0)};
    req_data  = {32'hDEADBEEF ^ 32'h2, 32'hDEADBEEF ^ 32'h1, 32'hDEADBEEF};
    wb_hold   = h;
  endtask

  task automatic reserve(input int a);
    req_valid = '0; sb_set_valid = 1'b1; sb_set_addr = AW'(a);
    settle();
    advance();
    sb_set_valid = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] v;
    int a0, a1, a2;
    bit hold;
    logic [N-1:0] rdy;
    bit wen;
    int waddr;
    bit chkd;
  } vec_t;

  vec_t tbl[20];
  int   res_list[11] = '{5, 4, 4, 1, 1, 2, 2, 3, 3, 6, 8};

  initial begin
    tbl[0]  = '{3'b001, 5, 0, 0, 0, 3'b001, 0, 0, 0};
    tbl[1]  = '{3'b000, 5, 0, 0, 0, 3'b000, 1, 5, 1};
    tbl[2]  = '{3'b000, 5, 0, 0, 0, 3'b000, 0, 5, 0};
    tbl[3]  = '{3'b100, 5, 0, 4, 0, 3'b100, 0, 5, 0};
    tbl[4]  = '{3'b111, 1, 2, 3, 0, 3'b001, 1, 4, 0};
    tbl[5]  = '{3'b111, 1, 2, 3, 0, 3'b010, 1, 1, 0};
    tbl[6]  = '{3'b111, 1, 2, 3, 0, 3'b100, 1, 2, 0};
    tbl[7]  = '{3'b111, 1, 2, 3, 0, 3'b001, 1, 3, 0};
    tbl[8]  = '{3'b111, 1, 2, 3, 0, 3'b010, 1, 1, 0};
    tbl[9]  = '{3'b111, 1, 2, 3, 0, 3'b100, 1, 2, 0};
    tbl[10] = '{3'b000, 1, 2, 3, 0, 3'b000, 1, 3, 0};
    tbl[11] = '{3'b010, 0, 0, 0, 0, 3'b010, 0, 3, 0};
    tbl[12] = '{3'b110, 0, 6, 8, 0, 3'b100, 0, 0, 0};
    tbl[13] = '{3'b111, 4, 6, 0, 1, 3'b000, 1, 8, 0};
    tbl[14] = '{3'b111, 4, 6, 0, 1, 3'b000, 0, 8, 0};
    tbl[15] = '{3'b111, 4, 6, 0, 1, 3'b000, 0, 8, 0};
    tbl[16] = '{3'b111, 4, 6, 0, 0, 3'b001, 0, 8, 0};
    tbl[17] = '{3'b110, 4, 6, 0, 0, 3'b010, 1, 4, 0};
    tbl[18] = '{3'b100, 4, 6, 0, 0, 3'b100, 1, 6, 0};
    tbl[19] = '{3'b000, 4, 6, 0, 0, 3'b000, 0, 0, 0};

    // Held in reset with requesters valid: nothing granted, outputs cleared.
    model_reset();
    req_valid = 3'b111;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    @(posedge clk); #1;

    foreach (res_list[i]) reserve(res_list[i]);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].hold);
      settle();
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_wen", i), 32'(rf_wen), 32'(tbl[i].wen));
      chk($sformatf("tbl%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].waddr));
      if (tbl[i].chkd) chk($sformatf("tbl%0d_wdata", i), rf_wdata, 32'hDEADBEEF);
      advance();
    end
    drive('0, 0, 0, 0, 0);

    // Scoreboard: two reservations on x7 retire one at a time.
    reserve(7); reserve(7);
    sb_raddr = 5'd7;
    settle(); chk("sb_x7_set", 32'(sb_busy), 32'd1); advance();
    drive(3'b001, WB_ALU + 7, 0, 0, 0);
    settle(); advance();
    drive('0, 0, 0, 0, 0);
    settle(); chk("sb_x7_wb1", 32'(sb_busy), 32'd1); advance();
    settle(); chk("sb_x7_after1", 32'(sb_busy), 32'd1); advance();
    drive(3'b001, 7, 0, 0, 0);
    settle(); advance();
    drive('0, 0, 0, 0, 0);
    settle(); chk("sb_x7_wb2", 32'(sb_busy), 32'd1); advance();
    settle(); chk("sb_x7_clear", 32'(sb_busy), 32'd0); advance();
    reserve(7); reserve(7); reserve(7);
    sb_set_valid = 1'b1; sb_set_addr = 5'd7;
    settle(); chk("sb_set_ready_sat", 32'(sb_set_ready), 32'd0); advance();
    sb_set_valid = 1'b0;

    // Reserve on x9 on the same edge x9 retires: count stays at one.
    reserve(9);
    drive(3'b001, 9, 0, 0, 0);
    settle(); advance();
    drive('0, 0, 0, 0, 0);
    sb_set_valid = 1'b1; sb_set_addr = 5'd9; sb_raddr = 5'd9;
    settle(); chk("sb_x9_pre", 32'(sb_busy), 32'd1); advance();
    sb_set_valid = 1'b0;
    settle(); chk("sb_x9_same_edge", 32'(sb_busy), 32'd1); advance();

    // Asynchronous reset mid-sequence with a write in flight.
    drive(3'b001, 7, 0, 0, 0);
    settle(); advance();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("mid_rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("mid_rst_rf_wdata", rf_wdata, 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    for (int a = 0; a < NREG; a++) begin
      sb_raddr = AW'(a);
      #1;
      chk($sformatf("mid_rst_busy_x%0d", a), 32'(sb_busy), 32'd0);
    end
    @(negedge clk);
    drive('0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic; writebacks only target previously reserved registers.
    for (int r = 0; r < NREG; r++) avail[r] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          int a, start, rr;
          a = 0;
          if ($urandom_range(0, 3) != 0) begin
            start = $urandom_range(1, NREG - 1);
            for (int k = 0; k < NREG - 1; k++) begin
              rr = 1 + ((start - 1 + k) % (NREG - 1));
              if (a == 0 && avail[rr] > 0) a = rr;
            end
          end
          if (a != 0) avail[a]--;
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'(a);
          req_data[i*DW +: DW] = $urandom;
        end
      end
      wb_hold      = ($urandom_range(0, 7) == 0);
      sb_set_valid = $urandom_range(0, 1) != 0;
      sb_set_addr  = AW'($urandom_range(0, 7));
      sb_raddr     = AW'($urandom_range(0, 7));
      settle();
      if (set_acc) avail[sb_set_addr]++;
      advance();
      for (int i = 0; i < N; i++) if (m_gnt[i]) req_valid[i] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wen/waddr/wdata) among NREQ writeback producers, e.g. ALU, load unit and CSR unit.
- Arbitration is round-robin with a valid/ready handshake; the winning write goes through one registered output stage that drives the register file directly.
- A per-register pending-write scoreboard tells decode whether a source register still awaits a writeback.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
CNT_W, 2, width of per-register pending-write counter

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  NREQ  requester i has a write pending
req_addr  in  NREQ*ADDR_WIDTH  destination register, requester i at slice i
req_data  in  NREQ*DATA_WIDTH  write data, requester i at slice i
req_ready  out  NREQ  one-hot grant; transfer when valid&ready
wb_hold  in  1  freeze arbitration (pipeline stall)
rf_wen  out  1  register-file write enable (registered)
rf_waddr  out  ADDR_WIDTH  register-file write address (registered)
rf_wdata  out  DATA_WIDTH  register-file write data (registered)
sb_set_valid  in  1  decode issues an instruction writing sb_set_addr
sb_set_addr  in  ADDR_WIDTH  destination being reserved
sb_set_ready  out  1  reservation accepted (counter not saturated)
sb_raddr  in  ADDR_WIDTH  scoreboard query address
sb_busy  out  1  queried register has pending writes

Behaviour:
- Reset (rst_n=0, asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, all pending counters=0. Any in-flight write is dropped. req_ready is 0 while rst_n=0.
- Grant (combinational):
  - Search req_valid starting at index rr_ptr, ascending with wrap to 0. The first valid index gets req_ready=1; all others 0.
  - No grant when wb_hold=1 or no valid requester.
  - req_ready never depends on the granted requester's own data.
- rr_ptr: on a transfer by index g, rr_ptr <= (g+1) mod NREQ. Otherwise it holds. With all requesters valid, grants rotate 0,1,2,0,...
- Output stage:
  - Transfer in cycle N: rf_waddr/rf_wdata <= granted slice at end of N.
  - rf_wen <= 1 unless the granted addr is 0, in which case rf_wen <= 0. An x0 transfer is still accepted and advances rr_ptr.
  - No transfer: rf_wen <= 0; addr and data hold their last values.
  - Write latency: the register file captures at end of N+1; the value is readable in N+2.
- wb_hold=1: no grants; the output stage still retires its current entry (rf_wen <= 0 next cycle). Requesters keep valid/addr/data stable until they are granted.
- Scoreboard: one CNT_W-bit counter per register 1..2^ADDR_WIDTH-1. x0 has no counter and always reads not busy.
  - sb_set_ready = (counter[sb_set_addr] != 2^CNT_W-1) or sb_set_addr==0.
  - inc = sb_set_valid & sb_set_ready & sb_set_addr!=0.
  - dec = rf_wen for rf_waddr, i.e. the same edge on which the register file writes.
  - Same register with inc and dec in one cycle: counter unchanged. Different registers: both update.
  - dec on a counter already at 0 is a protocol error; the counter stays 0 (no underflow), and the bench asserts that it never happens.
  - sb_busy = counter[sb_raddr] != 0, combinational. It deasserts in the cycle after the edge that writes the register, the same cycle the register-file read returns the new value.

Decomposition:
- Package rf_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH defaults
  - the NREQ default
  - requester index localparams (WB_ALU=0, WB_LSU=1, WB_CSR=2)
  - the x0 address constant
- One sub-module, rr_arbiter (NREQ parameter):
  - inputs: valid vector, enable, rr_ptr
  - outputs: one-hot grant and grant index
  - purely combinational
- rr_ptr, the output stage and the scoreboard counters stay in rf_wb_arbiter.

Test Plan:
1. Single write: req_valid=001, addr=5, data=0xDEADBEEF in cycle 0. Expect req_ready=001 in cycle 0; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 1; rf_wen=0 in cycle 2.
2. Round-robin: all three valid continuously for 6 cycles, distinct addrs 1/2/3. Expect grant order 0,1,2,0,1,2 and rf_waddr sequence 1,2,3,1,2,3 one cycle later.
3. x0 and hold:
   - x0: requester 1 writes addr 0. Expect req_ready=1 and rf_wen=0 next cycle; the next grant goes to index 2.
   - hold: wb_hold=1 for 3 cycles with valid=111. Expect req_ready=000 and rf_wen=0, then resumption at the preserved rr_ptr.
4. Scoreboard:
   - Set x7 twice. Expect sb_busy(7)=1.
   - One writeback to x7: still busy. Second writeback: sb_busy=0 in the cycle after the rf_wen=1 cycle.
   - Set x7 three times with CNT_W=2: sb_set_ready=0 on the fourth attempt.
5. Simultaneous events:
   - sb_set x9 in the same cycle as rf_wen for x9 with counter=1. Expect the counter to stay 1 and busy to stay 1.
   - rst_n pulsed low mid-sequence. Expect all outputs 0 immediately, counters cleared, and sb_busy=0 for every address.
